// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//
// Holds the default operand and group widths and a helper that derives the
// pipeline depth from the width parameters. The top-level module also guards
// against widths that do not split evenly into stage slices.
//
// Optional feature macro used by the slice: PIPELINED_CLA_SAT_EN (signed
// saturation in the final stage, adds the 'sat' port).
package pipelined_cla_adder_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_GROUP_W = 4;

  // Number of pipeline stages: one stage per slice of group_w*groups_per_stage bits.
  function automatic int calc_lat(input int width, input int group_w, input int groups_per_stage);
    return width / (group_w * groups_per_stage);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// cla_group: one GROUP_W-bit combinational carry-lookahead group.
//
// Ports:
//   a, b    : group operand bits (b is already the effective B)
//   cin     : carry into the group LSB
//   sum     : group sum bits
//   g, p    : group generate / propagate
//   cout    : carry out of the group MSB
//   c_msb   : carry into the group MSB (used for signed overflow)
module cla_group #(
  parameter int GROUP_W = 4
) (
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               g,
  output logic               p,
  output logic               cout,
  output logic               c_msb
);

  logic [GROUP_W-1:0] gen;
  logic [GROUP_W-1:0] prop;
  logic [GROUP_W-1:0] gpre;
  logic [GROUP_W-1:0] ppre;
  logic [GROUP_W:0]   c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Prefix generate/propagate over bits [i:0]; independent of cin so every
  // carry below is a single AND-OR away from the group carry-in.
  always_comb begin
    gpre    = '0;
    ppre    = '0;
    gpre[0] = gen[0];
    ppre[0] = prop[0];
    for (int i = 1; i < GROUP_W; i++) begin
      gpre[i] = gen[i] | (prop[i] & gpre[i-1]);
      ppre[i] = prop[i] & ppre[i-1];
    end
  end

  // Lookahead carries: c[i+1] = G[i:0] | P[i:0] & cin.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP_W; i++) begin
      c[i+1] = gpre[i] | (ppre[i] & cin);
    end
  end

  assign sum   = prop ^ c[GROUP_W-1:0];
  assign g     = gpre[GROUP_W-1];
  assign p     = ppre[GROUP_W-1];
  assign cout  = c[GROUP_W];
  assign c_msb = c[GROUP_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: parametrised pipelined carry-lookahead adder/subtractor
// with a valid/ready handshake and full backpressure.
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : operand beat handshake (in_ready = !out_valid || out_ready)
//   a, b, sub, cin      : operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid/out_ready : result handshake
//   f, cout, ovf, zero  : result and flags, registered together
//   sat                 : only with PIPELINED_CLA_SAT_EN; 1 when f was saturated
//
// Each of the LAT stages resolves one slice of GROUP_W*GROUPS_PER_STAGE bits,
// LSB first, and hands the still-unprocessed high operand bits, the finished
// low result bits and the slice carry to the next stage.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int GROUP_W          = DEF_GROUP_W,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero
`ifdef PIPELINED_CLA_SAT_EN
  ,
  output logic             sat
`endif
);

  localparam int SW  = GROUP_W * GROUPS_PER_STAGE;
  localparam int LAT = calc_lat(WIDTH, GROUP_W, GROUPS_PER_STAGE);

  if (WIDTH % SW != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP_W*GROUPS_PER_STAGE");
  end

  // The whole pipe moves in lockstep: it only stalls when the output holds a
  // result nobody has taken yet, and bubbles hold along with real beats.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int LO  = k * SW;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]              a_in;
    logic [REM-1:0]              b_in;
    logic                        c_in;
    logic                        v_in;
    logic [SW-1:0]               sum;
    logic [LO+SW-1:0]            r_out;
    logic [GROUPS_PER_STAGE:0]   gc;
    logic [GROUPS_PER_STAGE-1:0] gg;
    logic [GROUPS_PER_STAGE-1:0] gp;
    logic [GROUPS_PER_STAGE-1:0] gm;
    logic                        unused_grp;

    // Stage 0 applies the subtract inversion and the initial carry; later
    // stages pick up what the previous stage registered.
    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign r_out = sum;
    end else begin : g_chain
      assign a_in  = g_stage[k-1].g_pipe.a_q;
      assign b_in  = g_stage[k-1].g_pipe.b_q;
      assign c_in  = g_stage[k-1].g_pipe.c_q;
      assign v_in  = g_stage[k-1].g_pipe.v_q;
      assign r_out = {sum, g_stage[k-1].g_pipe.r_q};
    end

    // Groups inside one stage are chained on their carry-out.
    assign gc[0] = c_in;
    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
      cla_group #(.GROUP_W(GROUP_W)) u_grp (
        .a     (a_in[j*GROUP_W +: GROUP_W]),
        .b     (b_in[j*GROUP_W +: GROUP_W]),
        .cin   (gc[j]),
        .sum   (sum[j*GROUP_W +: GROUP_W]),
        .g     (gg[j]),
        .p     (gp[j]),
        .cout  (gc[j+1]),
        .c_msb (gm[j])
      );
    end

    // Group G/P and inner MSB carries are not needed by a ripple of groups.
    assign unused_grp = ^{gg, gp, gm};

    if (k < LAT - 1) begin : g_pipe
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;
      logic [LO+SW-1:0]  r_q;
      logic              c_q;
      logic              v_q;

      // Only the operand bits still to be added travel forward.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_in[REM-1:SW];
          b_q <= b_in[REM-1:SW];
          r_q <= r_out;
          c_q <= gc[GROUPS_PER_STAGE];
          v_q <= v_in;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] f_n;
      logic             ovf_n;

      assign ovf_n = gc[GROUPS_PER_STAGE] ^ gm[GROUPS_PER_STAGE-1];

`ifdef PIPELINED_CLA_SAT_EN
      localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
      // On overflow both operands share a sign, so A's MSB picks the rail.
      assign f_n = ovf_n ? (a_in[REM-1] ? MIN_NEG : MAX_POS) : r_out;
`else
      assign f_n = r_out;
`endif

      // Result and flags are captured together so they stay coherent
      // while the consumer stalls.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          f         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
`ifdef PIPELINED_CLA_SAT_EN
          sat       <= 1'b0;
`endif
        end else if (adv) begin
          out_valid <= v_in;
          f         <= f_n;
          cout      <= gc[GROUPS_PER_STAGE];
          ovf       <= ovf_n;
          zero      <= (f_n == '0);
`ifdef PIPELINED_CLA_SAT_EN
          sat       <= v_in & ovf_n;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: a 4-stage instance (defaults)
// and a single-stage instance (GROUPS_PER_STAGE=4) share clock and reset.
// Honours PIPELINED_CLA_SAT_EN when defined.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [15:0] f;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        sat;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, f;
  logic        l1_in_valid, l1_in_ready, l1_sub, l1_cin, l1_out_valid, l1_out_ready;
  logic        l1_cout, l1_ovf, l1_zero;
  logic [15:0] l1_a, l1_b, l1_f;
`ifdef PIPELINED_CLA_SAT_EN
  logic        sat, l1_sat;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  res_t exp_q[$];
  res_t exp1_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  pipelined_cla_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .ovf(ovf), .zero(zero)
`ifdef PIPELINED_CLA_SAT_EN
    , .sat(sat)
`endif
  );

  pipelined_cla_adder #(.WIDTH(16), .GROUP_W(4), .GROUPS_PER_STAGE(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(l1_in_valid), .in_ready(l1_in_ready),
    .a(l1_a), .b(l1_b), .sub(l1_sub), .cin(l1_cin), .out_valid(l1_out_valid),
    .out_ready(l1_out_ready), .f(l1_f), .cout(l1_cout), .ovf(l1_ovf), .zero(l1_zero)
`ifdef PIPELINED_CLA_SAT_EN
    , .sat(l1_sat)
`endif
  );

  // Arithmetic reference: full-width sum, overflow from operand/result signs.
  function automatic res_t ref_model(input logic [15:0] x, input logic [15:0] y,
                                     input logic s, input logic ci);
    logic [15:0] ye;
    logic [16:0] tot;
    res_t        r;
    ye     = s ? ~y : y;
    tot    = {1'b0, x} + {1'b0, ye} + {16'd0, (s ? 1'b1 : ci)};
    r.f    = tot[15:0];
    r.cout = tot[16];
    r.ovf  = (x[15] == ye[15]) && (r.f[15] != x[15]);
    r.sat  = 1'b0;
`ifdef PIPELINED_CLA_SAT_EN
    if (r.ovf) begin
      r.sat = 1'b1;
      r.f   = x[15] ? 16'h8000 : 16'h7FFF;
    end
`endif
    r.zero = (r.f == 16'h0000);
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic s,
                              input logic ci, input logic [15:0] ef, input logic ec,
                              input logic eo, input logic ez, input logic es);
    vec_t v;
    v.a = x; v.b = y; v.sub = s; v.cin = ci;
    v.exp.f = ef; v.exp.cout = ec; v.exp.ovf = eo; v.exp.zero = ez; v.exp.sat = es;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_vec++;
    if (actual !== required) begin
      n_err++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic cmpRes(input string tag, input logic [15:0] af, input logic ac, input logic ao,
                        input logic az, input logic as_, input res_t e);
    checkOutput({tag, " f"}, af, e.f);
    checkOutput({tag, " cout"}, ac, e.cout);
    checkOutput({tag, " ovf"}, ao, e.ovf);
    checkOutput({tag, " zero"}, az, e.zero);
`ifdef PIPELINED_CLA_SAT_EN
    checkOutput({tag, " sat"}, as_, e.sat);
`else
    if (as_ === 1'bx) $display("[TB] note: sat sample undefined in %s", tag);
`endif
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic s, input logic ci);
    a = x; b = y; sub = s; cin = ci; in_valid = 1'b1;
  endtask

  function automatic logic sat_of_dut();
`ifdef PIPELINED_CLA_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic sat_of_dut1();
`ifdef PIPELINED_CLA_SAT_EN
    return l1_sat;
`else
    return 1'b0;
`endif
  endfunction

  // One beat through the 4-stage unit, checking latency and result.
  task automatic checkBeat(input string tag, input vec_t v);
    int lat;
    applyStimulus(v.a, v.b, v.sub, v.cin);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput({tag, " latency"}, lat, 4);
    cmpRes(tag, f, cout, ovf, zero, sat_of_dut(), v.exp);
    step();
  endtask

  // Back-to-back stream into the 4-stage unit with a scoreboard.
  task automatic runStream(input string tag, input int n, input bit rand_ready,
                           input int st_lo, input int st_hi, input int budget);
    int   sent, got;
    bit   acc;
    res_t e;
    sent = 0; got = 0;
    exp_q.delete();
    for (int c = 0; c < budget && got < n; c++) begin
      if (!in_valid && sent < n)
        applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : !(c >= st_lo && c <= st_hi);
      #1;
      if (c >= st_lo && c <= st_hi) begin
        checkOutput({tag, " stall in_ready"}, in_ready, 0);
        checkOutput({tag, " stall out_valid"}, out_valid, 1);
        if (exp_q.size() > 0) checkOutput({tag, " stall f"}, f, exp_q[0].f);
      end
      acc = 1'b0;
      if (out_valid && out_ready) begin
        checkOutput({tag, " beat expected"}, (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          cmpRes(tag, f, cout, ovf, zero, sat_of_dut(), e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a, b, sub, cin));
        sent++;
        acc = 1'b1;
      end
      step();
      if (acc) in_valid = 1'b0;
    end
    checkOutput({tag, " count"}, got, n);
    checkOutput({tag, " leftover"}, exp_q.size(), 0);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  // Random traffic and random backpressure into the single-stage unit.
  task automatic runRandom1(input int n, input int budget);
    int   sent, got;
    bit   acc;
    res_t e;
    sent = 0; got = 0;
    exp1_q.delete();
    for (int c = 0; c < budget && got < n; c++) begin
      if (!l1_in_valid && sent < n && $urandom_range(0, 3) != 0) begin
        l1_a = 16'($urandom); l1_b = 16'($urandom);
        l1_sub = 1'($urandom); l1_cin = 1'($urandom);
        l1_in_valid = 1'b1;
      end
      l1_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = 1'b0;
      if (l1_out_valid && l1_out_ready) begin
        checkOutput("rand1 beat expected", (exp1_q.size() > 0), 1);
        if (exp1_q.size() > 0) begin
          e = exp1_q.pop_front();
          cmpRes("rand1", l1_f, l1_cout, l1_ovf, l1_zero, sat_of_dut1(), e);
        end
        got++;
      end
      if (l1_in_valid && l1_in_ready) begin
        exp1_q.push_back(ref_model(l1_a, l1_b, l1_sub, l1_cin));
        sent++;
        acc = 1'b1;
      end
      step();
      if (acc) l1_in_valid = 1'b0;
    end
    checkOutput("rand1 count", got, n);
    checkOutput("rand1 leftover", exp1_q.size(), 0);
    l1_in_valid = 1'b0; l1_out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   stale;
    res_t e;

    vecs[0] = mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[2] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PIPELINED_CLA_SAT_EN
    vecs[3] = mk(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[4] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
`else
    vecs[3] = mk(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[4] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    vecs[5] = mk(16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[6] = mk(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7] = mk(16'h0010, 16'h0001, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    l1_in_valid = 1'b0; l1_a = '0; l1_b = '0; l1_sub = 1'b0; l1_cin = 1'b0; l1_out_ready = 1'b1;
    #13;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset f", f, 0);
    checkOutput("reset zero", zero, 0);
    checkOutput("reset l1 out_valid", l1_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    checkOutput("post reset in_ready", in_ready, 1);

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) checkBeat($sformatf("vec%0d", i), vecs[i]);

    $display("[TB] stream with mid-stream stall");
    runStream("stream", 6, 1'b0, 5, 7, 40);

    $display("[TB] random stream, 4 stages");
    runStream("rand4", 200, 1'b1, -1, -2, 2000);

    $display("[TB] reset with beats in flight");
    out_ready = 1'b1;
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0); step();
    applyStimulus(16'h0101, 16'h0202, 1'b0, 1'b0); step();
    applyStimulus(16'h00F0, 16'h000F, 1'b0, 1'b0); step();
    in_valid = 1'b0; step();
    checkOutput("pre-reset out_valid", out_valid, 1);
    checkOutput("pre-reset f", f, 16'h3333);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset f", f, 0);
    checkOutput("async reset cout", cout, 0);
    checkOutput("async reset ovf", ovf, 0);
    checkOutput("async reset zero", zero, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release in_ready", in_ready, 1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) stale = 1;
    end
    checkOutput("no stale beat", stale, 0);
    checkBeat("post reset", mk(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("[TB] single-stage configuration");
    l1_a = 16'h8000; l1_b = 16'h0001; l1_sub = 1'b1; l1_cin = 1'b0;
    l1_in_valid = 1'b1; l1_out_ready = 1'b1;
    e = ref_model(16'h8000, 16'h0001, 1'b1, 1'b0);
    step();
    l1_in_valid = 1'b0;
    checkOutput("lat1 latency", l1_out_valid, 1);
    cmpRes("lat1", l1_f, l1_cout, l1_ovf, l1_zero, sat_of_dut1(), e);
    step();
    checkOutput("lat1 drained", l1_out_valid, 0);
    runRandom1(1000, 6000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
